// File: rtl/sift_defs.sv
// rtl/sift_defs.sv - shared SIFT window constants
// Constants shared by the window generator and the convolution stage.
package sift_defs;
    localparam int SIFT_PIX_W    = 8;
    localparam int SIFT_WIN      = 11;
    localparam int SIFT_WIN_HALF = 5;
    localparam int SIFT_ROW_W    = 88;
    // Line-buffer word: the (SIFT_WIN-1) previous lines of one column.
    localparam int SIFT_LB_W     = (SIFT_WIN - 1) * SIFT_PIX_W;
endpackage

// File: rtl/sift_line_buf.sv
// rtl/sift_line_buf.sv - column-addressed line buffer, combinational read
// Ports: clk; we write enable; addr column; wdata write word; rdata read word (async read).
module sift_line_buf #(
    parameter int DEPTH = 640,
    parameter int DW    = 80,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/sift_win_gen.sv
// rtl/sift_win_gen.sv - 11x11 sliding pixel window generator for the SIFT pipeline
// Ports: clk; rst (async, active-low); pix_valid/pix_sof/pix_data raster input;
//   win_row0..win_row10 window lines y-10..y, [7:0] = newest column;
//   win_valid window pulse; frame_done end-of-frame pulse.
// Option SIFT_WIN_COORD_EN: adds ctr_x/ctr_y = window centre (x-5, y-5).
module sift_win_gen
    import sift_defs::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [SIFT_PIX_W-1:0] pix_data,
    output logic [SIFT_ROW_W-1:0] win_row0,
    output logic [SIFT_ROW_W-1:0] win_row1,
    output logic [SIFT_ROW_W-1:0] win_row2,
    output logic [SIFT_ROW_W-1:0] win_row3,
    output logic [SIFT_ROW_W-1:0] win_row4,
    output logic [SIFT_ROW_W-1:0] win_row5,
    output logic [SIFT_ROW_W-1:0] win_row6,
    output logic [SIFT_ROW_W-1:0] win_row7,
    output logic [SIFT_ROW_W-1:0] win_row8,
    output logic [SIFT_ROW_W-1:0] win_row9,
    output logic [SIFT_ROW_W-1:0] win_row10,
`ifdef SIFT_WIN_COORD_EN
    output logic [CW-1:0]         ctr_x,
    output logic [RW-1:0]         ctr_y,
`endif
    output logic                  win_valid,
    output logic                  frame_done
);
    localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] Y_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] X_MIN  = CW'(SIFT_WIN - 1);
    localparam logic [RW-1:0] Y_MIN  = RW'(SIFT_WIN - 1);

    logic [CW-1:0] x_q;
    logic [RW-1:0] y_q;
    logic [CW-1:0] cur_x;
    logic [RW-1:0] cur_y;
    logic          wrap;

    logic [SIFT_LB_W-1:0]  lb_rdata;
    logic [SIFT_LB_W-1:0]  lb_wdata;
    logic [SIFT_PIX_W-1:0] col [SIFT_WIN];
    logic [SIFT_ROW_W-1:0] win [SIFT_WIN];

    // sof forces the accepted pixel to (0,0) regardless of the counters.
    assign cur_x = pix_sof ? '0 : x_q;
    assign cur_y = pix_sof ? '0 : y_q;
    assign wrap  = (cur_x == X_LAST) && (cur_y == Y_LAST);

    // Line-buffer word holds the oldest line (y-10) in [7:0] and y-1 in the top byte;
    // the write shifts out the oldest line and appends the current pixel.
    assign lb_wdata = {pix_data, lb_rdata[SIFT_LB_W-1:SIFT_PIX_W]};

    sift_line_buf #(
        .DEPTH (IMG_W),
        .DW    (SIFT_LB_W),
        .AW    (CW)
    ) u_line_buf (
        .clk   (clk),
        .we    (pix_valid),
        .addr  (cur_x),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    always_comb begin
        for (int k = 0; k < SIFT_WIN - 1; k++) col[k] = lb_rdata[k*SIFT_PIX_W +: SIFT_PIX_W];
        col[SIFT_WIN-1] = pix_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q        <= '0;
            y_q        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int r = 0; r < SIFT_WIN; r++) win[r] <= '0;
`ifdef SIFT_WIN_COORD_EN
            ctr_x      <= '0;
            ctr_y      <= '0;
`endif
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                if (cur_x == X_LAST) begin
                    x_q <= '0;
                    y_q <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
                end else begin
                    x_q <= cur_x + 1'b1;
                    y_q <= cur_y;
                end
                for (int r = 0; r < SIFT_WIN; r++)
                    win[r] <= {win[r][SIFT_ROW_W-SIFT_PIX_W-1:0], col[r]};
                // Gating on x/y also hides stale line-buffer data after reset or restart.
                win_valid  <= (cur_x >= X_MIN) && (cur_y >= Y_MIN);
                frame_done <= wrap;
`ifdef SIFT_WIN_COORD_EN
                ctr_x      <= cur_x - CW'(SIFT_WIN_HALF);
                ctr_y      <= cur_y - RW'(SIFT_WIN_HALF);
`endif
            end
        end
    end

    assign win_row0  = win[0];
    assign win_row1  = win[1];
    assign win_row2  = win[2];
    assign win_row3  = win[3];
    assign win_row4  = win[4];
    assign win_row5  = win[5];
    assign win_row6  = win[6];
    assign win_row7  = win[7];
    assign win_row8  = win[8];
    assign win_row9  = win[9];
    assign win_row10 = win[10];
endmodule

// File: tb/tb_sift_win_gen.sv
// tb/tb_sift_win_gen.sv - directed self-checking bench for sift_win_gen (16x12 image)
module tb_sift_win_gen;
    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int CW    = 4;
    localparam int RW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [7:0]  pix_data = '0;
    logic [87:0] row [11];
    logic        win_valid;
    logic        frame_done;
`ifdef SIFT_WIN_COORD_EN
    logic [CW-1:0] ctr_x;
    logic [RW-1:0] ctr_y;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int dones;
    logic [87:0] first_win;

    always #5 clk = ~clk;

    sift_win_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_data   (pix_data),
        .win_row0   (row[0]),
        .win_row1   (row[1]),
        .win_row2   (row[2]),
        .win_row3   (row[3]),
        .win_row4   (row[4]),
        .win_row5   (row[5]),
        .win_row6   (row[6]),
        .win_row7   (row[7]),
        .win_row8   (row[8]),
        .win_row9   (row[9]),
        .win_row10  (row[10]),
`ifdef SIFT_WIN_COORD_EN
        .ctr_x      (ctr_x),
        .ctr_y      (ctr_y),
`endif
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    function automatic logic [7:0] pix(input int x, input int y, input logic [7:0] off);
        logic [7:0] b;
        b = 8'((16 * y + x) & 8'hFF);
        return b + off;
    endfunction

    // Expected window line r for current pixel (x,y): byte k = P(x-k, y-10+r).
    function automatic logic [87:0] exp_row(input int r, input int x, input int y, input logic [7:0] off);
        logic [87:0] v;
        for (int k = 0; k < 11; k++) v[8*k +: 8] = pix(x - k, y - 10 + r, off);
        return v;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        @(posedge clk);
        #1;
    endtask

    // One full frame; checks every cycle's valid/done timing and every valid window's contents.
    task automatic run_frame(input logic [7:0] off, input logic sof_first, input bit rnd,
                             output int n_pulse, output int n_done, output logic [87:0] first0);
        logic exp_v;
        n_pulse = 0;
        n_done  = 0;
        first0  = '0;
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                while (rnd && $urandom_range(0, 1) == 0) begin
                    drive(1'b0, 1'b0, 8'h5A);
                    n_checks++;
                    if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle_pulse: valid=%b done=%b required 0 0", win_valid, frame_done);
                    end
                end
                drive(1'b1, sof_first && x == 0 && y == 0, pix(x, y, off));
                exp_v = (x >= 10) && (y >= 10);
                n_checks++;
                if (win_valid !== exp_v) begin
                    n_fail++;
                    $display("FAIL win_valid_timing (%0d,%0d): got %b required %b", x, y, win_valid, exp_v);
                end
                if (win_valid === 1'b1) begin
                    n_pulse++;
                    if (n_pulse == 1) first0 = row[0];
                    for (int r = 0; r < 11; r++) begin
                        n_checks++;
                        if (row[r] !== exp_row(r, x, y, off)) begin
                            n_fail++;
                            $display("FAIL win_row%0d (%0d,%0d): got %h required %h", r, x, y, row[r], exp_row(r, x, y, off));
                        end
                    end
`ifdef SIFT_WIN_COORD_EN
                    n_checks++;
                    if (ctr_x !== CW'(x - 5) || ctr_y !== RW'(y - 5)) begin
                        n_fail++;
                        $display("FAIL ctr_xy (%0d,%0d): got %0d,%0d required %0d,%0d", x, y, ctr_x, ctr_y, x - 5, y - 5);
                    end
`endif
                end
                n_checks++;
                if (frame_done !== (x == IMG_W - 1 && y == IMG_H - 1)) begin
                    n_fail++;
                    $display("FAIL frame_done_timing (%0d,%0d): got %b", x, y, frame_done);
                end
                if (frame_done === 1'b1) n_done++;
            end
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 25; i++) drive(1'b1, i == 0, 8'hC3);
        #3 rst = 1'b0;
        #1;
        for (int r = 0; r < 11; r++) begin
            n_checks++;
            if (row[r] !== '0) begin
                n_fail++;
                $display("FAIL reset_row%0d: got %h required 0", r, row[r]);
            end
        end
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b done=%b required 0 0", win_valid, frame_done);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        // No sof: the first pixel after reset must be (0,0).
        run_frame(8'h00, 1'b0, 1'b0, pulses, dones, first_win);
        n_checks++;
        if (pulses != 12 || dones != 1) begin
            n_fail++;
            $display("FAIL reset_frame_counts: pulses=%0d dones=%0d required 12 1", pulses, dones);
        end
    endtask

    task automatic test_full_frame;
        run_frame(8'h00, 1'b1, 1'b0, pulses, dones, first_win);
        n_checks++;
        if (first_win !== 88'h00_01_02_03_04_05_06_07_08_09_0A) begin
            n_fail++;
            $display("FAIL first_win_row0: got %h required 000102030405060708090a", first_win);
        end
        n_checks++;
        if (pulses != 12 || dones != 1) begin
            n_fail++;
            $display("FAIL full_counts: pulses=%0d dones=%0d required 12 1", pulses, dones);
        end
    endtask

    task automatic test_random_valid;
        run_frame(8'h00, 1'b1, 1'b1, pulses, dones, first_win);
        n_checks++;
        if (pulses != 12 || dones != 1) begin
            n_fail++;
            $display("FAIL random_counts: pulses=%0d dones=%0d required 12 1", pulses, dones);
        end
    endtask

    task automatic test_sof_restart;
        for (int i = 0; i < 39; i++) begin
            drive(1'b1, i == 0, pix(i % IMG_W, i / IMG_W, 8'h00));
            n_checks++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL pre_sof_pulse %0d: valid=%b done=%b required 0 0", i, win_valid, frame_done);
            end
        end
        run_frame(8'h00, 1'b1, 1'b0, pulses, dones, first_win);
        n_checks++;
        if (first_win !== 88'h00_01_02_03_04_05_06_07_08_09_0A || pulses != 12 || dones != 1) begin
            n_fail++;
            $display("FAIL sof_restart: row0=%h pulses=%0d dones=%0d required 000102030405060708090a 12 1",
                     first_win, pulses, dones);
        end
    endtask

    task automatic test_back_to_back;
        int p0, d0, p1, d1;
        logic [87:0] f1;
        run_frame(8'h00, 1'b1, 1'b0, p0, d0, first_win);
        run_frame(8'h01, 1'b0, 1'b0, p1, d1, f1);
        n_checks++;
        if (p0 != 12 || p1 != 12 || d0 + d1 != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: pulses=%0d,%0d dones=%0d required 12,12 2", p0, p1, d0 + d1);
        end
        n_checks++;
        if (f1 !== 88'h01_02_03_04_05_06_07_08_09_0A_0B) begin
            n_fail++;
            $display("FAIL b2b_first_row0: got %h required 0102030405060708090a0b", f1);
        end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_random_valid;
        test_sof_restart;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
